usr_param: RTL and testbench
============================

USR_PARAM -- requirements
Module: usr_param

Interface
REQ-001 Parameter WIDTH, default 8: register width in bits; SHALL be >= 2.
REQ-002 Parameter CW, default $clog2(WIDTH+1): width of the burst count port; SHALL be derived, not overridden.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  operation enable; 0 SHALL hold all state except reset.
REQ-006 s  input  3  mode select, decoded per REQ-012.
REQ-007 din  input  WIDTH  parallel load data.
REQ-008 cnt  input  CW  burst shift count, sampled only at burst start.
REQ-009 s_rightdin  input  1  serial input entering the MSB on right-type shifts.
REQ-010 s_leftdin  input  1  serial input entering the LSB on left shifts.
REQ-011 The outputs SHALL be:
- dout  output  WIDTH  register contents.
- s_rightdout  output  1  equal to dout[0], combinational from dout.
- s_leftdout  output  1  equal to dout[WIDTH-1], combinational from dout.
- busy  output  1  burst in progress, registered.
- done  output  1  one-cycle burst-complete pulse, registered.

Function
REQ-012 In IDLE with en=1, s SHALL select the single-cycle update of dout:
- 000: hold.
- 001: shift right, {s_rightdin, dout[W-1:1]}.
- 010: shift left, {dout[W-2:0], s_leftdin}.
- 011: parallel load din.
- 100: rotate right.
- 101: rotate left.
- 110: arithmetic shift right (MSB replicated).
- 111: burst start.
REQ-013 The FSM SHALL have two states, IDLE and BURST, plus a down-counter rem of width CW.
REQ-014 Burst start (IDLE, en=1, s=111) SHALL load rem <= min(cnt, WIDTH) and leave dout unchanged.
REQ-015 At burst start, if the loaded count is non-zero the FSM SHALL go to BURST and busy SHALL read 1 from the next cycle.
REQ-016 At burst start, if cnt=0 the FSM SHALL stay IDLE, no shift SHALL occur, and done SHALL pulse for one cycle after that edge.
REQ-017 In BURST with en=1, each edge SHALL perform one shift right with s_rightdin fill and decrement rem.
REQ-018 In BURST, the edge on which rem goes 1->0 SHALL return the FSM to IDLE, clear busy and set done for exactly one cycle.
REQ-019 In BURST with en=0, dout and rem SHALL freeze and busy SHALL remain 1.
REQ-020 In BURST, s, din and cnt SHALL be ignored; a new command SHALL be accepted only in IDLE.
REQ-021 A burst with count N SHALL complete N+1 enabled edges after the start edge, counting the start edge.
REQ-022 done SHALL be 0 on every cycle except those defined in REQ-016 and REQ-018.
REQ-023 A shift that drops a bit SHALL make that bit visible on s_rightdout or s_leftdout on the cycle before the edge that drops it.

Reset
REQ-024 With rst=1 at an edge: dout=0, rem=0, FSM=IDLE, busy=0, done=0, regardless of en, s or the current state.
REQ-025 Reset SHALL take priority over every operation, including mid-burst; no done pulse SHALL follow an aborted burst.
REQ-026 With dout=0 after reset, s_rightdout and s_leftdout SHALL read 0.

Verification (WIDTH=8)
REQ-027 Load/shift: load 0xA5, then s=001 with s_rightdin=1 -> dout=0xD2; s_rightdout=1 before the shift edge.
REQ-028 Rotate/arith: rotate left on 0x81 -> 0x03; arithmetic shift right on 0x80 -> 0xC0; shift left on 0x80 with s_leftdin=0 -> 0x00.
REQ-029 Burst: dout=0xF0, s_rightdin=0, s=111, cnt=3 -> busy=1 for 3 cycles, dout=0x1E, done=1 for one cycle, then idle.
REQ-030 Burst stall and edges:
- en=0 for 2 cycles mid-burst -> completion delayed by exactly 2 cycles.
- cnt=0 -> done pulse with dout unchanged and busy never 1.
- cnt=15 -> exactly 8 shifts.
REQ-031 Reset mid-burst: rst=1 after 2 of 5 shifts -> dout=0, busy=0, no done pulse; the next s=011 load is accepted.
REQ-032 Enable/ignore: en=0 with any s -> dout unchanged; changing s, din or cnt during BURST -> no effect on the result.

Source files
------------

// File: rtl/usr_param_if.sv
// Command/data bundle for the universal shift register.
// master drives mode, data and serial inputs; slave returns register state and burst status.
// No flow control: commands are sampled on every enabled clock edge.
interface usr_param_if #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             en;
    logic [2:0]       s;
    logic [WIDTH-1:0] din;
    logic [CW-1:0]    cnt;
    logic             s_rightdin;
    logic             s_leftdin;
    logic [WIDTH-1:0] dout;
    logic             s_rightdout;
    logic             s_leftdout;
    logic             busy;
    logic             done;

    modport master (
        output en, s, din, cnt, s_rightdin, s_leftdin,
        input  dout, s_rightdout, s_leftdout, busy, done
    );

    modport slave (
        input  en, s, din, cnt, s_rightdin, s_leftdin,
        output dout, s_rightdout, s_leftdout, busy, done
    );
endinterface

// File: rtl/usr_param.sv
// Universal shift register: hold/shift/rotate/arith/load plus a counted right-shift burst.
// Single-cycle ops take effect on the next edge; a burst of N finishes N edges after its start edge.
// en=0 freezes register and counter; new commands are accepted only while not busy.
module usr_param #(
    parameter int WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    usr_param_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [CW-1:0]    rem;
    logic [WIDTH-1:0] dout_q;
    logic             busy_q;
    logic             done_q;
    logic [CW-1:0]    cnt_clamped;
    logic [WIDTH-1:0] shr_fill;

    // Counts beyond WIDTH would only shift in fill bits again; clamp them.
    always_comb begin
        cnt_clamped = (bus.cnt > CW'(WIDTH)) ? CW'(WIDTH) : bus.cnt;
        shr_fill    = {bus.s_rightdin, dout_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rem    <= '0;
            dout_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.en) begin
                case (state)
                    IDLE: begin
                        case (bus.s)
                            3'b001: dout_q <= shr_fill;
                            3'b010: dout_q <= {dout_q[WIDTH-2:0], bus.s_leftdin};
                            3'b011: dout_q <= bus.din;
                            3'b100: dout_q <= {dout_q[0], dout_q[WIDTH-1:1]};
                            3'b101: dout_q <= {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
                            3'b110: dout_q <= {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
                            3'b111: begin
                                rem <= cnt_clamped;
                                if (cnt_clamped != '0) begin
                                    state  <= BURST;
                                    busy_q <= 1'b1;
                                end else begin
                                    done_q <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    BURST: begin
                        dout_q <= shr_fill;
                        rem    <= rem - CW'(1);
                        if (rem == CW'(1)) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dout        = dout_q;
    assign bus.s_rightdout = dout_q[0];
    assign bus.s_leftdout  = dout_q[WIDTH-1];
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_usr_param.sv
// Bench for usr_param (WIDTH=8): directed scenarios then random traffic,
// all checked every cycle against an arithmetic reference model.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_usr_param;
    localparam int W    = 8;
    localparam int MASK = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    usr_param_if #(.WIDTH(W)) bus ();

    usr_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference state: register value, shifts still owed by a burst, pulse flags.
    int m_dout = 0;
    int m_left = 0;
    bit m_busy = 0;
    bit m_done = 0;

    task automatic model_step();
        int sr;
        int sl;
        sr = int'(bus.s_rightdin);
        sl = int'(bus.s_leftdin);
        if (rst) begin
            m_dout = 0; m_left = 0; m_busy = 0; m_done = 0;
            return;
        end
        m_done = 0;
        if (!bus.en) return;
        if (m_busy) begin
            m_dout = (m_dout >> 1) | (sr << (W - 1));
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end else begin
            case (int'(bus.s))
                1: m_dout = (m_dout >> 1) | (sr << (W - 1));
                2: m_dout = ((m_dout << 1) & MASK) | sl;
                3: m_dout = int'(bus.din);
                4: m_dout = (m_dout >> 1) | ((m_dout & 1) << (W - 1));
                5: m_dout = ((m_dout << 1) & MASK) | (m_dout >> (W - 1));
                6: m_dout = (m_dout >> 1) | (m_dout & (1 << (W - 1)));
                7: begin
                    m_left = (int'(bus.cnt) > W) ? W : int'(bus.cnt);
                    if (m_left == 0) m_done = 1;
                    else m_busy = 1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("dout",   32'(bus.dout),   32'(m_dout));
        chk("busy",   32'(bus.busy),   32'(m_busy));
        chk("done",   32'(bus.done),   32'(m_done));
        chk("rdout",  32'(bus.s_rightdout), 32'(m_dout & 1));
        chk("ldout",  32'(bus.s_leftdout),  32'((m_dout >> (W - 1)) & 1));
    endtask

    task automatic cmd(input logic e, input logic [2:0] sel, input logic [7:0] d,
                       input logic [3:0] c, input logic sr, input logic sl);
        bus.en = e; bus.s = sel; bus.din = d; bus.cnt = c;
        bus.s_rightdin = sr; bus.s_leftdin = sl;
    endtask

    task automatic load(input logic [7:0] d);
        cmd(1'b1, 3'b011, d, 4'd0, 1'b0, 1'b0);
        tick();
    endtask

    initial begin
        int cycles;
        int shifts;
        cmd(1'b1, 3'b011, 8'hFF, 4'd0, 1'b1, 1'b1);

        // Reset wins over a pending load
        rst = 1'b1;
        tick();
        tick();
        chk("rst_dout", 32'(bus.dout), 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        chk("rst_rdout", 32'(bus.s_rightdout), 32'h0);
        chk("rst_ldout", 32'(bus.s_leftdout), 32'h0);
        rst = 1'b0;

        // Load then shift right with 1 fill
        load(8'hA5);
        chk("load_a5", 32'(bus.dout), 32'hA5);
        cmd(1'b1, 3'b001, 8'h00, 4'd0, 1'b1, 1'b0);
        chk("rdout_before_shift", 32'(bus.s_rightdout), 32'h1);
        tick();
        chk("shr_d2", 32'(bus.dout), 32'hD2);

        // Rotate, arithmetic shift, left shift
        load(8'h81);
        cmd(1'b1, 3'b101, 8'h00, 4'd0, 1'b0, 1'b0);
        tick();
        chk("rol_03", 32'(bus.dout), 32'h03);
        load(8'h80);
        cmd(1'b1, 3'b110, 8'h00, 4'd0, 1'b0, 1'b0);
        tick();
        chk("asr_c0", 32'(bus.dout), 32'hC0);
        load(8'h80);
        cmd(1'b1, 3'b010, 8'h00, 4'd0, 1'b0, 1'b0);
        chk("ldout_before_shl", 32'(bus.s_leftdout), 32'h1);
        tick();
        chk("shl_00", 32'(bus.dout), 32'h00);
        load(8'h01);
        cmd(1'b1, 3'b100, 8'h00, 4'd0, 1'b0, 1'b0);
        tick();
        chk("ror_80", 32'(bus.dout), 32'h80);

        // Burst of 3 on 0xF0
        load(8'hF0);
        cmd(1'b1, 3'b111, 8'h00, 4'd3, 1'b0, 1'b0);
        tick();
        cmd(1'b1, 3'b000, 8'h00, 4'd0, 1'b0, 1'b0);
        cycles = 0;
        while (bus.busy && cycles < 20) begin
            cycles++;
            if (bus.busy) tick();
        end
        chk("burst3_busy_cycles", 32'(cycles), 32'd3);
        chk("burst3_dout", 32'(bus.dout), 32'h1E);
        chk("burst3_done", 32'(bus.done), 32'h1);
        tick();
        chk("burst3_done_clear", 32'(bus.done), 32'h0);

        // Burst of 3 with a 2-cycle stall after the first shift
        load(8'hF0);
        cmd(1'b1, 3'b111, 8'h00, 4'd3, 1'b0, 1'b0);
        tick();
        cmd(1'b1, 3'b000, 8'h00, 4'd0, 1'b0, 1'b0);
        tick();
        bus.en = 1'b0;
        tick();
        tick();
        chk("stall_busy", 32'(bus.busy), 32'h1);
        chk("stall_dout", 32'(bus.dout), 32'h78);
        bus.en = 1'b1;
        cycles = 4;
        while (!bus.done && cycles < 30) begin
            tick();
            cycles++;
        end
        chk("stall_total_edges", 32'(cycles), 32'd6);
        chk("stall_dout_end", 32'(bus.dout), 32'h1E);

        // Zero-count burst
        load(8'h5A);
        cmd(1'b1, 3'b111, 8'h00, 4'd0, 1'b1, 1'b1);
        tick();
        chk("cnt0_done", 32'(bus.done), 32'h1);
        chk("cnt0_busy", 32'(bus.busy), 32'h0);
        chk("cnt0_dout", 32'(bus.dout), 32'h5A);
        cmd(1'b1, 3'b000, 8'h00, 4'd0, 1'b0, 1'b0);
        tick();
        chk("cnt0_done_clear", 32'(bus.done), 32'h0);

        // Oversized count clamps to WIDTH shifts
        load(8'hFF);
        cmd(1'b1, 3'b111, 8'h00, 4'd15, 1'b0, 1'b0);
        tick();
        shifts = 0;
        while (!bus.done && shifts < 30) begin
            tick();
            shifts++;
        end
        chk("cnt15_shifts", 32'(shifts), 32'd8);
        chk("cnt15_dout", 32'(bus.dout), 32'h00);

        // Reset after 2 of 5 shifts aborts without a done pulse
        load(8'hFF);
        cmd(1'b1, 3'b111, 8'h00, 4'd5, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk("abort_mid_dout", 32'(bus.dout), 32'h3F);
        rst = 1'b1;
        tick();
        chk("abort_dout", 32'(bus.dout), 32'h0);
        chk("abort_busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        cmd(1'b1, 3'b000, 8'h00, 4'd0, 1'b0, 1'b0);
        tick();
        chk("abort_no_done", 32'(bus.done), 32'h0);
        load(8'h3C);
        chk("abort_load", 32'(bus.dout), 32'h3C);

        // en=0 holds under every mode
        load(8'h96);
        for (int i = 0; i < 8; i++) begin
            cmd(1'b0, 3'(i), 8'h00, 4'd1, 1'b1, 1'b1);
            tick();
        end
        chk("en0_hold", 32'(bus.dout), 32'h96);

        // s/din/cnt changes during a burst are ignored
        cmd(1'b1, 3'b111, 8'h00, 4'd2, 1'b1, 1'b0);
        tick();
        cmd(1'b1, 3'b011, 8'h00, 4'd7, 1'b1, 1'b0);
        tick();
        cmd(1'b1, 3'b111, 8'h55, 4'd0, 1'b1, 1'b1);
        tick();
        chk("ignore_dout", 32'(bus.dout), 32'hE5);
        chk("ignore_done", 32'(bus.done), 32'h1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            cmd(($urandom_range(0, 7) != 0), 3'($urandom), 8'($urandom), 4'($urandom),
                1'($urandom), 1'($urandom));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
